// File: rtl/sprite_scheduler.sv
// Per-frame sequencer for one sprite engine: latches sprite state on each frame pulse,
// starts the engine on the sprite's top line, and offsets the engine into an animation strip ROM.
module sprite_scheduler #(
  parameter int WIDTH     = 8,
  parameter int HEIGHT    = 8,
  parameter int NFRAMES   = 4,
  parameter int ANIM_DIV  = 8,
  parameter int CORDW     = 16,
  parameter int ADDRW     = 6,
  parameter int ROM_ADDRW = 8,
  localparam int FW       = (NFRAMES > 1) ? $clog2(NFRAMES) : 1,
  localparam int DIVW     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_frame,
  input  logic                    i_line,
  input  logic signed [CORDW-1:0] i_sy,
  input  logic signed [CORDW-1:0] i_spr_x,
  input  logic signed [CORDW-1:0] i_spr_y,
  input  logic                    i_face,
  input  logic                    i_anim_en,
  input  logic [ADDRW-1:0]        i_spr_pos,
  input  logic                    i_spr_done,
  output logic                    o_spr_start,
  output logic signed [CORDW-1:0] o_spr_x,
  output logic                    o_spr_face,
  output logic [ROM_ADDRW-1:0]    o_rom_addr,
  output logic [FW-1:0]           o_anim_frame,
  output logic                    o_busy,
  output logic                    o_overrun
);

  typedef enum logic [1:0] {IDLE, ARMED, START, RUN} state_t;
  state_t state, state_nxt;

  logic signed [CORDW-1:0] lat_x, lat_y;
  logic                    lat_face;
  logic [DIVW-1:0]         anim_div;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      ARMED:   if (i_line && i_sy == lat_y) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (i_spr_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A frame pulse re-arms from any state and swallows a same-cycle line pulse.
    if (i_frame) state_nxt = ARMED;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lat_x        <= '0;
      lat_y        <= '0;
      lat_face     <= 1'b0;
      o_spr_x      <= '0;
      o_spr_face   <= 1'b0;
      anim_div     <= '0;
      o_anim_frame <= '0;
      o_overrun    <= 1'b0;
    end else begin
      o_spr_x    <= lat_x;
      o_spr_face <= lat_face;
      if (i_frame) begin
        lat_x    <= i_spr_x;
        lat_y    <= i_spr_y;
        lat_face <= i_face;
        if (state == START || state == RUN) o_overrun <= 1'b1;
        if (i_anim_en) begin
          if (anim_div == DIVW'(ANIM_DIV - 1)) begin
            anim_div     <= '0;
            o_anim_frame <= (o_anim_frame == FW'(NFRAMES - 1)) ? '0 : o_anim_frame + 1'b1;
          end else begin
            anim_div <= anim_div + 1'b1;
          end
        end
      end
    end
  end

  assign o_spr_start = (state == START);
  assign o_busy      = (state == RUN);

  // Combinational so the engine's BRAM look-ahead timing is unchanged.
  assign o_rom_addr = ROM_ADDRW'(o_anim_frame) * ROM_ADDRW'(WIDTH * HEIGHT)
                    + ROM_ADDRW'(i_spr_pos);

endmodule
